// File: rtl/counter_ctrl.sv
// counter_ctrl: synchronizes and debounces board buttons/switches and drives a 16-bit up/down/auto counter.
// Define COUNTER_CTRL_BCD_MODE_EN to count in four packed BCD digits (0000..9999) instead of binary.

module counter_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sync_in,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The count goes 0..DEBOUNCE_CYCLES-1, so the state changes on the edge that would reach the last value.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_LOW: begin
        if (sync_in) begin
          state_next = S_WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync_in) begin
          state_next = S_LOW;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == CNT_LAST) state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          state_next = S_WAIT_LOW;
          cnt_next   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync_in) begin
          state_next = S_HIGH;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == CNT_LAST) state_next = S_LOW;
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign level = (state == S_HIGH) || (state == S_WAIT_LOW);

endmodule

module counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 100000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_clear,
  input  logic        auto_en,
  input  logic        dir,
  output logic [15:0] sixteen_bit_number,
  output logic        wrap
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  // Bit order of the synchronizer vector: up, down, clear, auto_en, dir.
  logic [4:0] sync_meta, sync_q;
  logic [2:0] btn_level;
  logic [1:0] level_d;
  logic [PW-1:0] presc;
  logic up_press, down_press, clear_level, auto_sync, dir_sync, tick;
  logic step_en, step_up, step_wrap;
  logic [15:0] step_value;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {dir, auto_en, btn_clear, btn_down, btn_up};
      sync_q    <= sync_meta;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    counter_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock  (clock),
      .reset_n(reset_n),
      .sync_in(sync_q[i]),
      .level  (btn_level[i])
    );
  end

  // A press is the first cycle a debounced level is high, i.e. right after S_WAIT_HIGH -> S_HIGH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) level_d <= '0;
    else          level_d <= btn_level[1:0];
  end

  assign up_press    = btn_level[0] & ~level_d[0];
  assign down_press  = btn_level[1] & ~level_d[1];
  assign clear_level = btn_level[2];
  assign auto_sync   = sync_q[3];
  assign dir_sync    = sync_q[4];
  assign tick        = auto_sync && (presc == PRESC_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                presc <= '0;
    else if (!auto_sync || tick) presc <= '0;
    else                         presc <= presc + 1'b1;
  end

`ifdef COUNTER_CTRL_BCD_MODE_EN
  function automatic logic [16:0] step_count(input logic [15:0] value, input logic up);
    logic [16:0] result;
    logic        carry;
    logic [3:0]  digit;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit = value[i*4 +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) digit = 4'd0;
          else begin
            digit = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) digit = 4'd9;
          else begin
            digit = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
      result[i*4 +: 4] = digit;
    end
    result[16] = carry;
    return result;
  endfunction
`else
  function automatic logic [16:0] step_count(input logic [15:0] value, input logic up);
    if (up) return {value == 16'hFFFF, value + 16'd1};
    return {value == 16'h0000, value - 16'd1};
  endfunction
`endif

  // Presses beat ticks; simultaneous up and down presses cancel and also swallow any tick.
  always_comb begin
    step_en = 1'b0;
    step_up = 1'b0;
    if (up_press && !down_press) begin
      step_en = 1'b1;
      step_up = 1'b1;
    end else if (down_press && !up_press) begin
      step_en = 1'b1;
    end else if (!up_press && !down_press && tick) begin
      step_en = 1'b1;
      step_up = dir_sync;
    end
    {step_wrap, step_value} = step_count(sixteen_bit_number, step_up);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sixteen_bit_number <= '0;
      wrap               <= 1'b0;
    end else if (clear_level) begin
      sixteen_bit_number <= '0;
      wrap               <= 1'b0;
    end else if (step_en) begin
      sixteen_bit_number <= step_value;
      wrap               <= step_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: a cycle-level reference model queues the expected output every clock,
// an independent monitor pops and compares on the falling edge. Honors COUNTER_CTRL_BCD_MODE_EN.

module tb_counter_ctrl;

  localparam int DB = 4;
  localparam int TK = 5;

`ifdef COUNTER_CTRL_BCD_MODE_EN
  localparam logic [15:0] EXP_UNDER = 16'h9999;
  localparam logic [15:0] EXP_TEN   = 16'h0010;
  localparam logic [15:0] EXP_15    = 16'h0015;
  localparam logic [15:0] EXP_16    = 16'h0016;
  localparam logic [15:0] EXP_13    = 16'h0013;
`else
  localparam logic [15:0] EXP_UNDER = 16'hFFFF;
  localparam logic [15:0] EXP_TEN   = 16'h000A;
  localparam logic [15:0] EXP_15    = 16'h000F;
  localparam logic [15:0] EXP_16    = 16'h0010;
  localparam logic [15:0] EXP_13    = 16'h000D;
`endif

  logic        clock;
  logic        reset_n;
  logic        btn_up, btn_down, btn_clear, auto_en, dir;
  logic [15:0] sixteen_bit_number;
  logic        wrap;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] count;
    logic        wrap;
  } exp_t;

  exp_t sbq[$];

  counter_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_CYCLES    (TK)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_clear         (btn_clear),
    .auto_en           (auto_en),
    .dir               (dir),
    .sixteen_bit_number(sixteen_bit_number),
    .wrap              (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: synchronized samples, debounced levels with stable-run lengths, pending presses.
  logic [4:0]  m_s1, m_s2;
  logic [2:0]  m_lvl, m_press;
  int          m_run[3];
  int          m_phase;
  logic [15:0] m_count;
  logic        m_wrap;

  function automatic logic [15:0] model_step(input logic [15:0] v, input int delta, output logic wrapped);
`ifdef COUNTER_CTRL_BCD_MODE_EN
    int n;
    n = v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0] + delta;
    wrapped = (n < 0) || (n > 9999);
    n = (n + 10000) % 10000;
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
`else
    int n;
    n = int'(v) + delta;
    wrapped = (n < 0) || (n > 65535);
    n = (n + 65536) % 65536;
    return 16'(n);
`endif
  endfunction

  always @(posedge clock) begin
    logic clr, up_pr, dn_pr, tick;
    int   delta;
    exp_t e;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
      m_run = '{0, 0, 0}; m_phase = 0; m_count = '0; m_wrap = 1'b0;
    end else begin
      clr   = m_lvl[2];
      up_pr = m_press[0];
      dn_pr = m_press[1];
      tick  = m_s2[3] && (m_phase == TK - 1);
      delta = 0;
      if (!clr) begin
        if (up_pr != dn_pr)    delta = up_pr ? 1 : -1;
        else if (!up_pr && tick) delta = m_s2[4] ? 1 : -1;
      end
      m_wrap = 1'b0;
      if (clr)             m_count = '0;
      else if (delta != 0) m_count = model_step(m_count, delta, m_wrap);
      m_phase = m_s2[3] ? (m_phase + 1) % TK : 0;
      m_press = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i]   = m_s2[i];
            m_press[i] = m_s2[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {dir, auto_en, btn_clear, btn_down, btn_up};
    end
    e.count = m_count;
    e.wrap  = m_wrap;
    sbq.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (sixteen_bit_number !== e.count) begin
        failures++;
        $display("[TB] FAIL sb_count @%0t: got %h expected %h", $time, sixteen_bit_number, e.count);
      end
      checks++;
      if (wrap !== e.wrap) begin
        failures++;
        $display("[TB] FAIL sb_wrap @%0t: got %b expected %b", $time, wrap, e.wrap);
      end
    end
  end

  task automatic applyStimulus(input logic up, input logic down, input logic clr,
                               input logic ae, input logic dr, input int cycles);
    btn_up    = up;
    btn_down  = down;
    btn_clear = clr;
    auto_en   = ae;
    dir       = dr;
    repeat (cycles) @(negedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp_count, input logic exp_wrap);
    checks++;
    if (sixteen_bit_number !== exp_count || wrap !== exp_wrap) begin
      failures++;
      $display("[TB] FAIL %s: got count=%h wrap=%b, expected count=%h wrap=%b",
               name, sixteen_bit_number, wrap, exp_count, exp_wrap);
    end
  endtask

  task automatic pressUp();
    applyStimulus(1, 0, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 8);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_up = 0; btn_down = 0; btn_clear = 0; auto_en = 0; dir = 0;
    repeat (3) @(negedge clock);
    #1;
    reset_n = 1'b1;
    $display("[TB] reset released");
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkOutput("reset_idle", 16'h0000, 1'b0);

    // Held button: exactly one step, seven edges after the raw edge.
    applyStimulus(1, 0, 0, 0, 0, 6);
    checkOutput("press_latency_before", 16'h0000, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("press_latency_at", 16'h0001, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 13);
    checkOutput("held_no_repeat", 16'h0001, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 8);
    pressUp();
    checkOutput("second_press", 16'h0002, 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 2);
      applyStimulus(0, 0, 0, 0, 0, 2);
    end
    applyStimulus(0, 0, 0, 0, 0, 8);
    checkOutput("bounce_rejected", 16'h0002, 1'b0);

    // Underflow and overflow around zero.
    applyStimulus(0, 0, 1, 0, 0, 8);
    applyStimulus(0, 0, 0, 0, 0, 8);
    checkOutput("clear_to_zero", 16'h0000, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 7);
    checkOutput("underflow_wrap", EXP_UNDER, 1'b1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("wrap_one_cycle", EXP_UNDER, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 8);
    applyStimulus(1, 0, 0, 0, 0, 7);
    checkOutput("overflow_wrap", 16'h0000, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 8);
    for (int i = 0; i < 10; i++) pressUp();
    checkOutput("ten_presses", EXP_TEN, 1'b0);

    // Auto-count up, press coinciding with a tick, then auto-count down.
    applyStimulus(0, 0, 0, 1, 1, 26);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("auto_up_5_steps", EXP_15, 1'b0);
    applyStimulus(1, 0, 0, 1, 1, 7);
    checkOutput("press_with_tick", EXP_16, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 15);
    applyStimulus(0, 0, 0, 0, 0, 4);
    checkOutput("auto_down_3_steps", EXP_13, 1'b0);

    // Clear dominates ticks; reset mid-debounce restarts the press from scratch.
    applyStimulus(0, 0, 1, 1, 1, 20);
    checkOutput("clear_holds_zero", 16'h0000, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkOutput("clear_released", 16'h0000, 1'b0);
    pressUp();
    checkOutput("before_reset", 16'h0001, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 4);
    reset_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 2);
    checkOutput("in_reset", 16'h0000, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 6);
    checkOutput("post_reset_before", 16'h0000, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("post_reset_press", 16'h0001, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 8);

    $display("[TB] random phase");
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 2);
        reset_n = 1'b1;
      end
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    applyStimulus(0, 0, 0, 0, 0, 20);

    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drained: got %0d entries left, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
